key_scheduler: RTL



---
 rtl/rc4_pkg.sv | 21 ++
 rtl/trap_edge.sv | 21 ++
 rtl/key_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: KSA state encoding and S-box sizing constants.
// State bit 1 doubles as the RAM write enable and bit 3 as the finished flag.
package rc4_pkg;

  localparam int unsigned S_ENTRIES  = 256;
  localparam logic [7:0]  LAST_INDEX = 8'hFF;

  typedef enum logic [7:0] {
    StIdle    = 8'h00,
    StInit    = 8'h02,
    StDone    = 8'h08,
    StAddrI   = 8'h10,
    StWaitSi  = 8'h20,
    StReadSi  = 8'h30,
    StWaitSj  = 8'h40,
    StReadSj  = 8'h50,
    StWriteSi = 8'h62,
    StWriteSj = 8'h72
  } ksa_state_t;

endpackage

// File: rtl/trap_edge.sv
// Rising-edge detector: one-cycle pulse when level goes from low to high.
module trap_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/key_scheduler.sv
// RC4 key-scheduling engine: fills the S RAM with the identity permutation, then scrambles it
// with the secret key. Optional observation ports are enabled by KEY_SCHEDULER_TAPS_EN.
module key_scheduler
  import rc4_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 8,
  parameter int unsigned RAM_LENGTH = 8,
  parameter int unsigned KEY_LENGTH = 3,
  parameter int unsigned KEY_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_BITS-1:0]   secret_key,
  input  logic [RAM_WIDTH-1:0]  sOut,
  output logic [RAM_WIDTH-1:0]  sIn,
  output logic [RAM_LENGTH-1:0] sAddr,
  output logic                  sWren,
`ifdef KEY_SCHEDULER_TAPS_EN
  output logic [7:0]            iTap,
  output logic [7:0]            jTap,
  output logic [7:0]            stateTap,
  output logic [7:0]            kTap,
  output logic                  wrenTap,
`endif
  output logic                  finished
);

  localparam int unsigned KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam logic [RAM_LENGTH-1:0] LAST_I = RAM_LENGTH'(LAST_INDEX);

  ksa_state_t              state_q, state_d;
  logic [RAM_LENGTH-1:0]   i_q, i_d, j_q, j_d, addr_q, addr_d;
  logic [RAM_WIDTH-1:0]    si_q, si_d, sj_q, sj_d;
  logic [KIDX_W-1:0]       kidx_q, kidx_d;
  logic [7:0]              key_byte;
  logic                    start_edge;

  trap_edge u_start_edge (
    .clk   (clk),
    .reset (reset),
    .level (start),
    .pulse (start_edge)
  );

  always_comb begin
    key_byte = 8'h00;
    for (int k = 0; k < int'(KEY_LENGTH); k++) begin
      if (kidx_q == KIDX_W'(k)) key_byte = secret_key[KEY_BITS-1-8*k -: 8];
    end
  end

  // Outputs of each state are loaded on the edge that enters it.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_edge) begin
          state_d = StInit;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          addr_d  = '0;
        end
      end
      StInit: begin
        if (i_q == LAST_I) begin
          state_d = StAddrI;
          i_d     = '0;
          j_d     = '0;
          addr_d  = '0;
        end else begin
          i_d    = i_q + 1'b1;
          addr_d = i_q + 1'b1;
        end
      end
      StAddrI:  state_d = StWaitSi;
      StWaitSi: state_d = StReadSi;
      StReadSi: begin
        state_d = StWaitSj;
        si_d    = sOut;
        j_d     = j_q + RAM_LENGTH'(sOut) + RAM_LENGTH'(key_byte);
        addr_d  = j_d;
      end
      StWaitSj: state_d = StReadSj;
      StReadSj: begin
        state_d = StWriteSi;
        sj_d    = sOut;
        addr_d  = i_q;
      end
      StWriteSi: begin
        state_d = StWriteSj;
        addr_d  = j_q;
      end
      StWriteSj: begin
        kidx_d = (kidx_q == KIDX_W'(KEY_LENGTH - 1)) ? '0 : kidx_q + 1'b1;
        if (i_q == LAST_I) begin
          state_d = StDone;
          addr_d  = '0;
        end else begin
          state_d = StAddrI;
          i_d     = i_q + 1'b1;
          addr_d  = i_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    sIn = '0;
    unique case (state_q)
      StInit:    sIn = RAM_WIDTH'(i_q);
      StWriteSi: sIn = sj_q;
      StWriteSj: sIn = si_q;
      default:   sIn = '0;
    endcase
  end

  assign sAddr    = addr_q;
  assign sWren    = state_q[1];
  assign finished = state_q[3];

`ifdef KEY_SCHEDULER_TAPS_EN
  assign iTap     = 8'(i_q);
  assign jTap     = 8'(j_q);
  assign stateTap = state_q;
  assign kTap     = 8'(kidx_q);
  assign wrenTap  = sWren;
`endif

endmodule
